// File: rtl/video_source_switch_ctrl.sv
// Frame-safe selector between live ISP video and the test-pattern generator (pixel_clock domain).
// Optional live-loss fallback is compiled in when SRC_LOSS_FALLBACK_EN is defined.
module video_source_switch_ctrl #(
    parameter int DATA_W         = 24,
    parameter bit VSYNC_POL      = 1'b1,
    parameter bit HSYNC_POL      = 1'b1,
    parameter int TPG_RST_CYCLES = 4,
    parameter int LOSS_TIMEOUT   = 8800
) (
    input  logic              pixel_clock,
    input  logic              reset,
    input  logic              sel_req,
    input  logic              live_vsync,
    input  logic              live_hsync,
    input  logic              live_den,
    input  logic              live_line_start,
    input  logic [DATA_W-1:0] live_pixel,
    input  logic              tpg_vsync,
    input  logic              tpg_hsync,
    input  logic              tpg_den,
    input  logic              tpg_line_start,
    input  logic [DATA_W-1:0] tpg_pixel,
    output logic              tpg_reset,
    output logic              out_vsync,
    output logic              out_hsync,
    output logic              out_den,
    output logic              out_line_start,
    output logic [DATA_W-1:0] out_pixel,
    output logic              active_src,
    output logic              switch_busy,
    output logic              live_lost
);
    typedef enum logic [1:0] { ST_RUN, ST_WAIT_EOF, ST_ALIGN } state_t;

    typedef struct packed {
        logic              vsync;
        logic              hsync;
        logic              den;
        logic              line_start;
        logic [DATA_W-1:0] pixel;
    } vid_t;

    localparam int   RC_W  = (TPG_RST_CYCLES < 1) ? 1 : $clog2(TPG_RST_CYCLES + 1);
    localparam vid_t BLANK = '{vsync: ~VSYNC_POL, hsync: ~HSYNC_POL, den: 1'b0,
                               line_start: 1'b0, pixel: '0};

    if (TPG_RST_CYCLES < 1 || LOSS_TIMEOUT < 2) begin : g_bad_param
        $error("video_source_switch_ctrl: TPG_RST_CYCLES must be >=1 and LOSS_TIMEOUT >=2");
    end

    state_t          state_q, state_d;
    logic            target_q, target_d;
    logic            active_q, active_d;
    logic            busy_q, busy_d;
    logic            trst_q, trst_d;
    logic            lost_q, lost_d;
    logic            rst_hold_q;
    logic            go_tpg;
    logic [RC_W-1:0] rcnt_q, rcnt_d;
    vid_t            out_q, out_d, live_v, tpg_v;
    logic            live_vs_q, tpg_vs_q;
    logic            live_edge, tpg_edge, act_edge;

    assign live_v = '{vsync: live_vsync, hsync: live_hsync, den: live_den,
                      line_start: live_line_start, pixel: live_pixel};
    assign tpg_v  = '{vsync: tpg_vsync, hsync: tpg_hsync, den: tpg_den,
                      line_start: tpg_line_start, pixel: tpg_pixel};

    assign live_edge = (live_vsync == VSYNC_POL) && !live_vs_q;
    assign tpg_edge  = (tpg_vsync == VSYNC_POL) && !tpg_vs_q;
    assign act_edge  = active_q ? live_edge : tpg_edge;

`ifdef SRC_LOSS_FALLBACK_EN
    localparam int LC_W = ($clog2(LOSS_TIMEOUT + 1) > 14) ? $clog2(LOSS_TIMEOUT + 1) : 14;

    logic [LC_W-1:0] loss_cnt_q, loss_cnt_d;

    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (live_line_start) begin
            loss_cnt_d = '0;
        end else if (loss_cnt_q != '1) begin
            loss_cnt_d = loss_cnt_q + 1'b1;
        end
    end

    // Look-ahead flag so the fallback transition lands on the same edge live_lost rises.
    assign lost_d = (loss_cnt_d >= LC_W'(LOSS_TIMEOUT));

    always_ff @(posedge pixel_clock) begin
        if (reset || rst_hold_q) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end
`else
    assign lost_d = 1'b0;
`endif

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        active_d = active_q;
        rcnt_d   = rcnt_q;
        trst_d   = 1'b0;
        go_tpg   = 1'b0;
        out_d    = active_q ? live_v : tpg_v;

        unique case (state_q)
            ST_RUN: begin
                if (active_q && lost_d) begin
                    go_tpg = 1'b1;
                end else if ((sel_req != active_q) && !(sel_req && lost_d)) begin
                    state_d  = ST_WAIT_EOF;
                    target_d = sel_req;
                end
            end
            ST_WAIT_EOF: begin
                if (active_q && lost_d) begin
                    go_tpg = 1'b1;
                end else if (sel_req == active_q) begin
                    state_d = ST_RUN;
                end else begin
                    target_d = sel_req;
                    if (act_edge) begin
                        if (sel_req) begin
                            state_d = ST_ALIGN;
                            out_d   = BLANK;
                        end else begin
                            go_tpg = 1'b1;
                        end
                    end
                end
            end
            ST_ALIGN: begin
                out_d = BLANK;
                if (!target_q) begin
                    if (rcnt_q == RC_W'(TPG_RST_CYCLES)) begin
                        state_d  = ST_RUN;
                        active_d = 1'b0;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                        trst_d = 1'b1;
                    end
                end else if (!sel_req || lost_d) begin
                    go_tpg = 1'b1;
                end else if (live_edge) begin
                    // The live vsync edge itself is forwarded so the first live frame is whole.
                    state_d  = ST_RUN;
                    active_d = 1'b1;
                    out_d    = live_v;
                end
            end
            default: begin
                go_tpg = 1'b1;
            end
        endcase

        if (go_tpg) begin
            state_d  = ST_ALIGN;
            target_d = 1'b0;
            trst_d   = 1'b1;
            rcnt_d   = RC_W'(1);
            out_d    = BLANK;
        end

        busy_d = (state_d != ST_RUN);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge pixel_clock) begin
        rst_hold_q <= reset;
        live_vs_q  <= (live_vsync == VSYNC_POL);
        tpg_vs_q   <= (tpg_vsync == VSYNC_POL);
        // Reset values are held for one extra cycle after reset drops.
        if (reset || rst_hold_q) begin
            state_q  <= ST_ALIGN;
            target_q <= 1'b0;
            active_q <= 1'b0;
            busy_q   <= 1'b1;
            trst_q   <= 1'b1;
            lost_q   <= 1'b0;
            rcnt_q   <= '0;
            out_q    <= BLANK;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            active_q <= active_d;
            busy_q   <= busy_d;
            trst_q   <= trst_d;
            lost_q   <= lost_d;
            rcnt_q   <= rcnt_d;
            out_q    <= out_d;
        end
    end

    assign tpg_reset      = trst_q;
    assign out_vsync      = out_q.vsync;
    assign out_hsync      = out_q.hsync;
    assign out_den        = out_q.den;
    assign out_line_start = out_q.line_start;
    assign out_pixel      = out_q.pixel;
    assign active_src     = active_q;
    assign switch_busy    = busy_q;
    assign live_lost      = lost_q;

endmodule
